// File: rtl/core_pkg.sv
// core_pkg
//   Shared types for the core's memory-side blocks.
//   data_type_t        : access size carried with every data request.
//   responder_state_t  : state encoding of data_mem_responder.
package core_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } data_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } responder_state_t;

endpackage

// File: rtl/mem_array_1rw.sv
// mem_array_1rw
//   Single-port 32-bit word array: synchronous byte-enabled write,
//   asynchronous (combinational) read. Contents are never reset.
//   Ports:
//     clk     : write clock
//     we_i    : write enable
//     be_i    : byte-lane enables, bit n writes wdata_i[8n+7:8n]
//     addr_i  : word index (shared by read and write)
//     wdata_i : write data, already lane-aligned
//     rdata_o : word at addr_i
module mem_array_1rw #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-side memory model for the core. Accepts one request at a time,
//   waits LATENCY cycles, then returns a single-cycle response.
//
//   Handshake: gnt_o = req_i while the FSM is IDLE; a request is taken in
//   the cycle where req_i and gnt_o are both 1, and the request fields are
//   captured then. Exactly one rvalid_o pulse follows, LATENCY+1 cycles
//   after the grant; err_o and rdata_o are only meaningful with rvalid_o
//   and are held at 0 otherwise.
//
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     req_i / gnt_o         : request / grant
//     we_i                  : 1 = store, 0 = load
//     addr_i                : byte address
//     wdata_i               : right-aligned store data
//     dtype_i               : access size (core_pkg::data_type_t encoding)
//     rvalid_o              : response pulse
//     rdata_o               : right-aligned, zero-extended load data
//     err_o                 : response is an error
//     dbg_state_o           : current FSM state, for observation only
module data_mem_responder
    import core_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  dtype_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int         IDX_W    = $clog2(MEM_WORDS);
    // Counter reload value; unused when LATENCY is 0.
    localparam logic [2:0] CNT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    responder_state_t state_q, state_d;
    logic [2:0]       cnt_q,   cnt_d;
    logic             we_q,    we_d;
    logic [31:0]      addr_q,  addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       dtype_q, dtype_d;

    logic        in_resp;
    logic        misaligned;
    logic        bad_dtype;
    logic        out_of_range;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdata_aligned;
    logic [31:0] mem_rdata;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;
    logic        mem_we;

    // rst_n gating keeps gnt_o low while reset is held even though
    // state_q already reads IDLE.
    assign gnt_o       = req_i && rst_n && (state_q == IDLE);
    assign in_resp     = (state_q == RESP);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dtype_d = dtype_q;
        case (state_q)
            IDLE: begin
                if (gnt_o) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    dtype_d = dtype_i;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            dtype_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dtype_q <= dtype_d;
        end
    end

    // Error checks work on the captured fields only.
    assign misaligned   = ((dtype_q == HALF_WORD) && addr_q[0]) ||
                          ((dtype_q == WORD) && (addr_q[1:0] != 2'b00));
    assign bad_dtype    = (dtype_q == 2'b11);
    assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(MEM_WORDS));
    assign err          = misaligned || bad_dtype || out_of_range;

    always_comb begin
        be = 4'b0000;
        case (dtype_q)
            BYTE:      be = 4'b0001 << addr_q[1:0];
            HALF_WORD: be = 4'b0011 << addr_q[1:0];
            WORD:      be = 4'b1111;
            default:   be = 4'b0000;
        endcase
    end

    assign wdata_aligned = wdata_q << {addr_q[1:0], 3'b000};

    // The write lands on the edge that closes RESP; an async reset during
    // RESP drops state_q to IDLE first, which kills the write.
    assign mem_we = in_resp && we_q && !err;

    mem_array_1rw #(
        .WORDS (MEM_WORDS),
        .AW    (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (be),
        .addr_i  (addr_q[IDX_W+1:2]),
        .wdata_i (wdata_aligned),
        .rdata_o (mem_rdata)
    );

    assign rd_shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = rd_shifted;
        case (dtype_q)
            BYTE:      load_data = {24'd0, rd_shifted[7:0]};
            HALF_WORD: load_data = {16'd0, rd_shifted[15:0]};
            default:   load_data = rd_shifted;
        endcase
    end

    assign rvalid_o = in_resp;
    assign err_o    = in_resp && err;
    assign rdata_o  = (in_resp && !err && !we_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    import core_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (LATENCY=1) ----------------
    logic        req_i   = 1'b0;
    logic        we_i    = 1'b0;
    logic [31:0] addr_i  = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [1:0]  dtype_i = 2'b00;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic [1:0]  dbg_state;

    data_mem_responder #(.MEM_WORDS(1024), .LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .dtype_i(dtype_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .dbg_state_o(dbg_state)
    );

    // ---------------- throughput DUTs (LATENCY=0 and 3) ----------------
    logic        req0 = 1'b0, req3 = 1'b0;
    logic        gnt0, rvalid0, err0, gnt3, rvalid3, err3;
    logic [31:0] rdata0, rdata3;
    logic [1:0]  dbg0, dbg3;

    data_mem_responder #(.MEM_WORDS(16), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .gnt_o(gnt0), .we_i(1'b1),
        .addr_i(32'h0000_0004), .wdata_i(32'h0102_0304), .dtype_i(2'b10),
        .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0),
        .dbg_state_o(dbg0)
    );

    data_mem_responder #(.MEM_WORDS(16), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .gnt_o(gnt3), .we_i(1'b1),
        .addr_i(32'h0000_0008), .wdata_i(32'h0506_0708), .dtype_i(2'b10),
        .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3),
        .dbg_state_o(dbg3)
    );

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];   // {err, rdata}
    int          gnt_q[$];   // grant cycle of each outstanding transaction
    logic [32:0] exp_e;
    int          g_cyc;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none (t=%0t)", name, $time);
    endfunction

    // Main monitor: pops expectations whenever the DUT responds.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt_o) gnt_q.push_back(cyc);
            if (rvalid_o) begin
                if (exp_q.size() == 0) begin
                    fail_event("unexpected_rvalid");
                end else begin
                    exp_e = exp_q.pop_front();
                    check("err", {31'd0, err_o}, {31'd0, exp_e[32]});
                    check("rdata", rdata_o, exp_e[31:0]);
                end
                if (gnt_q.size() == 0) begin
                    fail_event("rvalid_without_grant");
                end else begin
                    g_cyc = gnt_q.pop_front();
                    check("latency", 32'(cyc - g_cyc), 32'd2);
                end
            end else begin
                check("idle_err", {31'd0, err_o}, 32'd0);
                check("idle_rdata", rdata_o, 32'd0);
            end
        end
    end

    // Throughput monitor for the LATENCY=0 and LATENCY=3 instances.
    logic hs_on = 1'b0;
    int   last0, last3, ng0, ng3;

    always @(negedge clk) begin
        if (hs_on && rst_n) begin
            if (gnt0) begin
                if (last0 >= 0) check("gap_l0", 32'(cyc - last0), 32'd2);
                last0 = cyc;
                ng0++;
            end
            if (rvalid0) begin
                check("resp_l0", 32'(cyc - last0), 32'd1);
                check("resp_l0_err", {31'd0, err0}, 32'd0);
                check("resp_l0_rdata", rdata0, 32'd0);
            end
            if (gnt3) begin
                if (last3 >= 0) check("gap_l3", 32'(cyc - last3), 32'd5);
                last3 = cyc;
                ng3++;
            end
            if (rvalid3) begin
                check("resp_l3", 32'(cyc - last3), 32'd4);
                check("resp_l3_err", {31'd0, err3}, 32'd0);
                check("resp_l3_rdata", rdata3, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] t, input logic e, input logic [31:0] r,
                             input logic imm);
        int n;
        exp_q.push_back({e, r});
        @(posedge clk); #1;
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; dtype_i = t;
        @(negedge clk);
        if (imm) check("gnt_eq_req", {31'd0, gnt_o}, 32'd1);
        n = 0;
        while (!gnt_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!gnt_o) fail_event("gnt_timeout");
        // Scramble inputs after the grant: the transaction must not see them.
        @(posedge clk); #1;
        req_i = 1'b0; we_i = ~w; addr_i = $urandom; wdata_i = $urandom;
        dtype_i = 2'($urandom_range(0, 3));
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_event("rvalid_timeout");
            exp_q.delete();
            gnt_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        req_i = 1'b1;
        #12;
        check("rst_gnt", {31'd0, gnt_o}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        req_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        //        we    addr          wdata         dtype      err   rdata         imm
        do_access(1'b1, 32'h10,       32'hDEADBEEF, WORD,      1'b0, 32'h0,        1'b1);
        do_access(1'b0, 32'h10,       32'h0,        WORD,      1'b0, 32'hDEADBEEF, 1'b1);
        do_access(1'b1, 32'h13,       32'h123456AB, BYTE,      1'b0, 32'h0,        1'b0);
        do_access(1'b0, 32'h10,       32'h0,        WORD,      1'b0, 32'hABADBEEF, 1'b0);
        do_access(1'b0, 32'h12,       32'h0,        HALF_WORD, 1'b0, 32'h0000ABAD, 1'b0);
        do_access(1'b0, 32'h11,       32'h0,        BYTE,      1'b0, 32'h000000BE, 1'b0);
        do_access(1'b0, 32'h11,       32'h0,        HALF_WORD, 1'b1, 32'h0,        1'b0);
        do_access(1'b1, 32'h12,       32'h11111111, WORD,      1'b1, 32'h0,        1'b0);
        do_access(1'b0, 32'h10,       32'h0,        WORD,      1'b0, 32'hABADBEEF, 1'b0);
        do_access(1'b0, 32'h1000,     32'h0,        WORD,      1'b1, 32'h0,        1'b0);
        do_access(1'b0, 32'h10,       32'h0,        2'b11,     1'b1, 32'h0,        1'b0);
        do_access(1'b1, 32'h0,        32'h0BADF00D, WORD,      1'b0, 32'h0,        1'b0);
        do_access(1'b1, 32'h1000,     32'hFFFFFFFF, WORD,      1'b1, 32'h0,        1'b0);
        do_access(1'b0, 32'h0,        32'h0,        WORD,      1'b0, 32'h0BADF00D, 1'b0);
        do_access(1'b1, 32'h20,       32'hCAFEF00D, WORD,      1'b0, 32'h0,        1'b0);
        do_access(1'b1, 32'h22,       32'h9999BEEF, HALF_WORD, 1'b0, 32'h0,        1'b0);
        do_access(1'b0, 32'h20,       32'h0,        WORD,      1'b0, 32'hBEEFF00D, 1'b0);
        do_access(1'b0, 32'h23,       32'h0,        BYTE,      1'b0, 32'h000000BE, 1'b0);

        // Reset during WAIT of a store: no response, store discarded.
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h12345678; dtype_i = WORD;
        @(negedge clk);
        check("abort_gnt", {31'd0, gnt_o}, 32'd1);
        @(posedge clk); #1;
        req_i = 1'b0;
        check("abort_in_wait", {30'd0, dbg_state}, {30'd0, WAIT});
        rst_n = 1'b0;
        req_i = 1'b1;
        #1;
        check("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
        check("abort_gnt_low", {31'd0, gnt_o}, 32'd0);
        check("abort_rvalid", {31'd0, rvalid_o}, 32'd0);
        req_i = 1'b0;
        gnt_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        do_access(1'b0, 32'h20,       32'h0,        WORD,      1'b0, 32'hBEEFF00D, 1'b1);

        // Back-to-back requests with req held high.
        last0 = -1; last3 = -1; ng0 = 0; ng3 = 0;
        hs_on = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b1; req3 = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        req0 = 1'b0; req3 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        hs_on = 1'b0;
        check("grants_l0", 32'(ng0), 32'd12);
        check("grants_l3", 32'(ng3), 32'd5);
        check("end_state_l0", {30'd0, dbg0}, {30'd0, IDLE});
        check("end_state_l3", {30'd0, dbg3}, {30'd0, IDLE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
